// File: rtl/seq_mult_tx.sv
// seq_mult_tx: shift-and-add unsigned multiplier with a fixed latency of
// DATA_WIDTH cycles and a valid/ready hand-off of the finished product to a
// downstream register stage. Three-state control: IDLE -> RUN -> HOLD -> IDLE.
module seq_mult_tx #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                      slowClk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     opA,
    input  logic [DATA_WIDTH-1:0]     opB,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      out_valid,
    output logic [2*DATA_WIDTH-1:0]   product
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Counter value reached on the edge that performs the last iteration.
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;

    logic [PW-1:0]           mcand_r;
    logic [PW-1:0]           mcand_nxt_s;
    logic [DATA_WIDTH-1:0]   mplier_r;
    logic [DATA_WIDTH-1:0]   mplier_nxt_s;
    logic [PW-1:0]           acc_r;
    logic [PW-1:0]           acc_nxt_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_nxt_s;

    logic                    busy_r;
    logic                    out_valid_r;

    // Next-state and datapath next-value decode for the three-state controller.
    always_comb begin
        state_nxt_s  = state_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    // Operands are captured here only; later changes are ignored.
                    mcand_nxt_s  = {{DATA_WIDTH{1'b0}}, opA};
                    mplier_nxt_s = opB;
                    acc_nxt_s    = {PW{1'b0}};
                    cnt_nxt_s    = {CW{1'b0}};
                    state_nxt_s  = RUN;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end

            RUN: begin
                if (mplier_r[0]) begin
                    acc_nxt_s = acc_r + mcand_r;
                end else begin
                    acc_nxt_s = acc_r;
                end
                mcand_nxt_s  = {mcand_r[PW-2:0], 1'b0};
                mplier_nxt_s = {1'b0, mplier_r[DATA_WIDTH-1:1]};
                cnt_nxt_s    = cnt_r + CNT_ONE;
                // No early exit on a zero multiplier: latency is always fixed.
                if (cnt_nxt_s == CNT_LAST) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end

            HOLD: begin
                // Result and valid stay frozen until the downstream stage takes them.
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Controller state register with synchronous reset to IDLE.
    always_ff @(posedge slowClk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge slowClk) begin
        if (reset) begin
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {DATA_WIDTH{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            acc_r    <= acc_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Status flags registered from the next state so they track state_r exactly.
    always_ff @(posedge slowClk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            busy_r      <= (state_nxt_s != IDLE);
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    // The accumulator is the product register; it keeps its value through IDLE.
    assign product   = acc_r;

endmodule

// File: tb/tb_seq_mult_tx.sv
// Directed self-checking bench for seq_mult_tx with DATA_WIDTH = 4.
module tb_seq_mult_tx;

    logic       slowClk;
    logic       reset;
    logic       start;
    logic [3:0] opA;
    logic [3:0] opB;
    logic       out_ready;
    logic       busy;
    logic       out_valid;
    logic [7:0] product;

    int errors;
    int checks;

    seq_mult_tx #(.DATA_WIDTH(4)) dut (
        .slowClk   (slowClk),
        .reset     (reset),
        .start     (start),
        .opA       (opA),
        .opB       (opB),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .product   (product)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        slowClk = 1'b0;
        forever #5 slowClk = ~slowClk;
    end

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic tick();
        @(posedge slowClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One complete multiply with out_ready held high: checks latency, result, return to IDLE.
    task automatic do_mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] expected);
        opA       = a;
        opB       = b;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();                                   // accepting edge
        start = 1'b0;
        chk({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
        end
        tick();                                   // acceptance + 4
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_product"}, {24'd0, product}, {24'd0, expected});
        tick();                                   // transfer edge
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_product"}, {24'd0, product}, {24'd0, expected});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        opA       = 4'd0;
        opB       = 4'd0;
        out_ready = 1'b0;

        // Reset state
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_product", {24'd0, product}, 32'd0);
        tick();
        reset = 1'b0;

        // Basic, maximum and zero-operand multiplies
        do_mult("m3x5", 4'd3, 4'd5, 8'd15);
        do_mult("m15x15", 4'd15, 4'd15, 8'd225);
        do_mult("m0x9", 4'd0, 4'd9, 8'd0);

        // Backpressure: 7 x 6 held for 3 cycles with out_ready low
        opA       = 4'd7;
        opB       = 4'd6;
        start     = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_product", {24'd0, product}, 32'd42);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_product", {24'd0, product}, 32'd42);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_done_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("bp_single_xfer", {31'd0, out_valid}, 32'd0);

        // Ignored start: 2 x 7 captured, operands changed and start held high
        opA   = 4'd2;
        opB   = 4'd7;
        start = 1'b1;
        tick();                                   // accept 2 x 7
        opA = 4'd5;
        opB = 4'd5;
        for (int i = 1; i <= 4; i++) tick();
        chk("ign_valid", {31'd0, out_valid}, 32'd1);
        chk("ign_product", {24'd0, product}, 32'd14);
        tick();                                   // transfer edge, start high but not accepted
        chk("ign_xfer_busy", {31'd0, busy}, 32'd0);
        chk("ign_xfer_product", {24'd0, product}, 32'd14);
        tick();                                   // first IDLE edge accepts 5 x 5
        start = 1'b0;
        chk("ign_reaccept_busy", {31'd0, busy}, 32'd1);
        chk("ign_reaccept_clear", {24'd0, product}, 32'd0);
        for (int i = 1; i <= 4; i++) tick();
        chk("ign2_valid", {31'd0, out_valid}, 32'd1);
        chk("ign2_product", {24'd0, product}, 32'd25);
        tick();
        chk("ign2_idle", {31'd0, busy}, 32'd0);

        // Reset on the 2nd RUN edge, together with start to show reset priority
        opA   = 4'd9;
        opB   = 4'd9;
        start = 1'b1;
        tick();                                   // accept
        start = 1'b0;
        tick();                                   // 1st RUN edge
        chk("rmid_run_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();                                   // 2nd RUN edge with reset
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_product", {24'd0, product}, 32'd0);
        chk("rmid_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("rmid_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_mult("m2x3", 4'd2, 4'd3, 8'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_tx.md
SEQ_MULT_TX -- requirements
Module: seq_mult_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, the width of each operand (minimum 2).
REQ-002 SHALL have input slowClk, 1 bit, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, 1 bit, synchronous, active-high.
REQ-004 SHALL have input start, 1 bit, a request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have input opA, DATA_WIDTH bits, the unsigned multiplicand; captured on start acceptance.
REQ-006 SHALL have input opB, DATA_WIDTH bits, the unsigned multiplier; captured on start acceptance.
REQ-007 SHALL have input out_ready, 1 bit, asserted by the downstream sync register stage when it can take the result.
REQ-008 SHALL have output busy, 1 bit, high whenever state is not IDLE.
REQ-009 SHALL have output out_valid, 1 bit, high only in HOLD.
REQ-010 SHALL have output product, 2*DATA_WIDTH bits, the unsigned product, registered.

Function
REQ-011 SHALL implement exactly three states: IDLE, RUN, HOLD.
REQ-012 SHALL treat start as accepted at a rising edge where state is IDLE and start is 1; that edge loads opA zero-extended to 2*DATA_WIDTH into the multiplicand register, loads opB into the multiplier register, clears the accumulator to 0, clears the iteration counter to 0 and enters RUN.
REQ-013 SHALL, at each rising edge in RUN, add the multiplicand register to the accumulator if the multiplier register LSB is 1, then shift the multiplicand left by 1 and the multiplier right by 1 (zero fill), and increment the counter.
REQ-014 SHALL perform exactly DATA_WIDTH RUN iterations with no early termination when the multiplier becomes zero.
REQ-015 SHALL enter HOLD on the edge that performs iteration DATA_WIDTH; out_valid is then high from the edge at acceptance+DATA_WIDTH, i.e. fixed latency of DATA_WIDTH cycles after the accepting edge.
REQ-016 SHALL drive product from the accumulator; product is exact modulo 2^(2*DATA_WIDTH), and no overflow is possible.
REQ-017 SHALL hold product and out_valid stable in HOLD for as long as out_ready is 0 (unbounded backpressure).
REQ-018 SHALL complete the transfer at an edge where out_valid and out_ready are both 1, returning to IDLE; out_valid falls after that edge.
REQ-019 SHALL keep the last product value on the output in IDLE until the next accepted start clears it.
REQ-020 SHALL ignore start in RUN and HOLD, with no queuing; start high on the transfer edge is not accepted and must be held into the following IDLE cycle.
REQ-021 SHALL ignore out_ready outside HOLD.
REQ-022 SHALL ignore opA and opB changes after acceptance.
REQ-023 SHALL use a counter of clog2(DATA_WIDTH+1) bits with no wrap-around within one operation.

Reset
REQ-024 SHALL, when reset is 1 at a rising edge, force state to IDLE and clear the counter, accumulator (product), multiplicand and multiplier registers to 0, regardless of state.
REQ-025 SHALL take reset priority over start and out_ready in the same cycle.
REQ-026 SHALL make busy=0, out_valid=0 and product=0 observable after the first reset edge.
REQ-027 SHALL abort any operation in progress when reset is asserted during RUN or HOLD, discarding its result with no out_valid pulse.

Verification
REQ-028 SHALL cover the basic multiply with DATA_WIDTH=4: opA=3, opB=5, start pulse, out_ready=1 -> out_valid high exactly 4 edges after acceptance, product=15 (0x0F), IDLE on the next edge.
REQ-029 SHALL cover the maximum operands: opA=15, opB=15 -> product=225 (0xE1), latency still 4.
REQ-030 SHALL cover a zero operand: opA=0, opB=9 -> product=0, full 4-cycle latency, out_valid asserted.
REQ-031 SHALL cover backpressure: opA=7, opB=6, out_ready=0 for 3 cycles in HOLD, then 1 -> product=42 stable for all HOLD cycles, single transfer, then IDLE.
REQ-032 SHALL cover an ignored start: start held high through RUN with opA/opB changed -> result from the originally captured operands only; a new operation accepted only on the first IDLE edge.
REQ-033 SHALL cover reset mid-operation: reset asserted on the 2nd RUN edge -> busy=0, product=0, no out_valid; a following start with 2x3 yields 6.
